// File: rtl/meissa_column_ctrl_if.sv
// Bus bundle between the meissa column sequencer and its environment.
// slave: the controller; master: fetch buffers, column and result consumer.
interface meissa_column_ctrl_if #(
    parameter int unsigned COLUMN_WIDTH = 9,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MAC_WIDTH    = 32,
    parameter int unsigned CNT_WIDTH    = 8
);
    localparam int unsigned LW = DATA_WIDTH * COLUMN_WIDTH;
    localparam int unsigned MW = MAC_WIDTH * COLUMN_WIDTH;

    logic                 start;
    logic [CNT_WIDTH-1:0] k_len;
    logic                 busy;
    logic                 done;
    logic                 in_valid;
    logic                 in_ready;
    logic [LW-1:0]        in_data;
    logic [LW-1:0]        in_weight;
    logic                 pe_clear;
    logic [LW-1:0]        pe_datain;
    logic [LW-1:0]        pe_weight;
    logic [MW-1:0]        pe_maccout;
    logic                 out_valid;
    logic                 out_ready;
    logic [MW-1:0]        out_data;

    modport slave (
        input  start, k_len, in_valid, in_data, in_weight, pe_maccout, out_ready,
        output busy, done, in_ready, pe_clear, pe_datain, pe_weight, out_valid, out_data
    );

    modport master (
        output start, k_len, in_valid, in_data, in_weight, pe_maccout, out_ready,
        input  busy, done, in_ready, pe_clear, pe_datain, pe_weight, out_valid, out_data
    );
endinterface

// File: rtl/meissa_column_ctrl.sv
// Job sequencer for one meissa_column: clear, feed k_len beats, flush, hand off.
// Define MEISSA_COLUMN_CTRL_RELU_EN to zero negative lanes at result capture.
module meissa_column_ctrl #(
    parameter int unsigned ROW_WIDTH    = 8,
    parameter int unsigned COLUMN_WIDTH = 9,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MAC_WIDTH    = 32,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned PE_LAT       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    meissa_column_ctrl_if.slave   bus
);
    localparam int unsigned LW = DATA_WIDTH * COLUMN_WIDTH;
    localparam int unsigned MW = MAC_WIDTH * COLUMN_WIDTH;
    localparam int unsigned FW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    // ROW_WIDTH only sizes the PEs themselves; nothing to do here.
    if (ROW_WIDTH == 0) begin : g_no_rows
    end

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_HOLD} state_t;

    state_t               state, state_d;
    logic [CNT_WIDTH-1:0] k_len_q, k_len_d;
    logic [CNT_WIDTH-1:0] beat_cnt, beat_d;
    logic [FW-1:0]        flush_cnt, flush_d;
    logic [LW-1:0]        datain_d, weight_d;
    logic [MW-1:0]        out_data_d, captured;
    logic                 out_valid_d, done_d;
    logic                 beat;

    assign beat = bus.in_valid & bus.in_ready;

    // Result capture path, optionally rectifying each lane.
    always_comb begin
        captured = bus.pe_maccout;
`ifdef MEISSA_COLUMN_CTRL_RELU_EN
        for (int i = 0; i < int'(COLUMN_WIDTH); i++) begin
            if (bus.pe_maccout[MAC_WIDTH*i + MAC_WIDTH-1])
                captured[MAC_WIDTH*i +: MAC_WIDTH] = '0;
        end
`else
`endif
    end

    always_comb begin
        state_d     = state;
        k_len_d     = k_len_q;
        beat_d      = beat_cnt;
        flush_d     = flush_cnt;
        datain_d    = '0;
        weight_d    = '0;
        out_data_d  = bus.out_data;
        out_valid_d = bus.out_valid;
        done_d      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    k_len_d = bus.k_len;
                    beat_d  = '0;
                    flush_d = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = (k_len_q == '0) ? S_FLUSH : S_FEED;
            S_FEED: begin
                if (beat) begin
                    datain_d = bus.in_data;
                    weight_d = bus.in_weight;
                    beat_d   = beat_cnt + CNT_WIDTH'(1);
                    if (beat_cnt + CNT_WIDTH'(1) == k_len_q)
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == FW'(PE_LAT - 1)) begin
                    out_data_d  = captured;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    flush_d = flush_cnt + FW'(1);
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            k_len_q       <= '0;
            beat_cnt      <= '0;
            flush_cnt     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.pe_clear  <= 1'b0;
            bus.pe_datain <= '0;
            bus.pe_weight <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            state         <= state_d;
            k_len_q       <= k_len_d;
            beat_cnt      <= beat_d;
            flush_cnt     <= flush_d;
            bus.busy      <= (state_d != S_IDLE);
            bus.done      <= done_d;
            bus.in_ready  <= (state_d == S_FEED);
            bus.pe_clear  <= (state_d == S_CLEAR);
            bus.pe_datain <= datain_d;
            bus.pe_weight <= weight_d;
            bus.out_valid <= out_valid_d;
            bus.out_data  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_meissa_column_ctrl.sv
// Directed bench for meissa_column_ctrl with a behavioural accumulating column.
module tb_meissa_column_ctrl;
    localparam int unsigned COLW = 9;
    localparam int unsigned DW   = 16;
    localparam int unsigned MACW = 32;
    localparam int unsigned CW   = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;

    meissa_column_ctrl_if #(.COLUMN_WIDTH(COLW), .DATA_WIDTH(DW), .MAC_WIDTH(MACW), .CNT_WIDTH(CW)) bus ();

    meissa_column_ctrl #(
        .ROW_WIDTH(8), .COLUMN_WIDTH(COLW), .DATA_WIDTH(DW),
        .MAC_WIDTH(MACW), .CNT_WIDTH(CW), .PE_LAT(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Column model: per-lane signed MAC, cleared by reset or pe_clear.
    logic signed [MACW-1:0] acc [COLW];
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(COLW); i++) begin
            if (reset || bus.pe_clear)
                acc[i] <= '0;
            else
                acc[i] <= acc[i] + 32'(signed'(bus.pe_datain[DW*i +: DW])) *
                                   32'(signed'(bus.pe_weight[DW*i +: DW]));
        end
    end
    always_comb begin
        for (int i = 0; i < int'(COLW); i++)
            bus.pe_maccout[MACW*i +: MACW] = acc[i];
    end

    typedef struct {
        int          k;
        logic [15:0] d;
        logic [15:0] w;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic set_lanes(input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] dr, input logic [15:0] w);
        for (int i = 0; i < int'(COLW); i++) begin
            bus.in_data[DW*i +: DW]   = (i == 0) ? d0 : (i == 1) ? d1 : dr;
            bus.in_weight[DW*i +: DW] = w;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},      64'(bus.busy), 0);
        check({tag, "_done"},      64'(bus.done), 0);
        check({tag, "_in_ready"},  64'(bus.in_ready), 0);
        check({tag, "_pe_clear"},  64'(bus.pe_clear), 0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 0);
        check({tag, "_pe_datain"}, 64'(|bus.pe_datain), 0);
        check({tag, "_pe_weight"}, 64'(|bus.pe_weight), 0);
        check({tag, "_out_data"},  64'(|bus.out_data), 0);
    endtask

    // Full job with in_valid/out_ready high; start raised in cycle 0.
    task automatic run_job(input int k, input logic [15:0] d, input logic [15:0] w,
                           input logic [31:0] exp);
        int c;
        c = 0;
        set_lanes(d, d, d, w);
        bus.k_len = CW'(k);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        while (c < 400) begin
            @(negedge clk);
            c++;
            bus.start = 1'b0;
            if (c == 1) begin
                check("pe_clear_high", 64'(bus.pe_clear), 1);
                check("busy_in_clear", 64'(bus.busy), 1);
            end
            if (c == 2) check("pe_clear_once", 64'(bus.pe_clear), 0);
            if (bus.out_valid) break;
        end
        check("out_valid_latency", 64'(c), 64'(k + 4));
        for (int i = 0; i < int'(COLW); i++)
            check($sformatf("out_data_k%0d_lane%0d", k, i), 64'(bus.out_data[MACW*i +: MACW]), 64'(exp));
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 1);
        check("out_valid_drop", 64'(bus.out_valid), 0);
        check("busy_after_job", 64'(bus.busy), 0);
        @(negedge clk);
        check("done_single", 64'(bus.done), 0);
    endtask

    initial begin
        int          c;
        int          beats;
        bit          saw_done;
        logic [4:0]  pat;
        logic [15:0] exp0, exp1;
        logic [31:0] held;

        vecs[0] = '{k: 4,   d: 16'd2,      w: 16'd3,      exp: 32'd24};
        vecs[1] = '{k: 1,   d: 16'd7,      w: 16'd5,      exp: 32'd35};
        vecs[2] = '{k: 10,  d: 16'd100,    w: 16'd100,    exp: 32'd100000};
        vecs[3] = '{k: 255, d: 16'd1,      w: 16'd1,      exp: 32'd255};
        vecs[4] = '{k: 0,   d: 16'd5,      w: 16'd5,      exp: 32'd0};
        vecs[5] = '{k: 3,   d: 16'hFFFF,   w: 16'hFFFF,   exp: 32'd3};
        vecs[6] = '{k: 2,   d: 16'h7FFF,   w: 16'h7FFF,   exp: 32'h7FFE0002};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_lanes(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        check_reset_state("init");
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++)
            run_job(vecs[v].k, vecs[v].d, vecs[v].w, vecs[v].exp);

        // Reset held 3 cycles in the middle of FEED aborts silently.
        set_lanes(16'd1, 16'd1, 16'd1, 16'd1);
        bus.k_len = 8'd10;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("in_ready_in_feed", 64'(bus.in_ready), 1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("midjob");
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("no_activity_after_reset", 64'(saw_done), 0);

        // in_valid pattern 1,0,1,0,1 in FEED; extra valid afterwards must be ignored.
        pat = 5'b10101;
        beats = 0;
        exp0 = '0;
        exp1 = '0;
        bus.k_len = 8'd3;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        c = 0;
        while (c < 60) begin
            @(negedge clk);
            c++;
            bus.start = 1'b0;
            if (bus.out_valid) break;
            if (c >= 3 && c <= 8) begin
                check($sformatf("pe_datain_lane0_c%0d", c), 64'(bus.pe_datain[15:0]), 64'(exp0));
                check($sformatf("pe_datain_lane1_c%0d", c), 64'(bus.pe_datain[31:16]), 64'(exp1));
            end
            exp0 = '0;
            exp1 = '0;
            if (c >= 2 && c <= 6) begin
                bus.in_valid = pat[c-2];
                if (pat[c-2])
                    set_lanes(16'(beats + 1), 16'(beats + 2), 16'(beats + 1), 16'd2);
                else
                    set_lanes(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
            end else if (c > 6) begin
                bus.in_valid = 1'b1;
                set_lanes(16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp0 = bus.in_data[15:0];
                exp1 = bus.in_data[31:16];
                beats++;
            end
        end
        check("toggle_beats", 64'(beats), 3);
        check("toggle_latency", 64'(c), 9);
        check("toggle_lane0", 64'(bus.out_data[31:0]), 12);
        check("toggle_lane1", 64'(bus.out_data[63:32]), 18);
        check("toggle_lane8", 64'(bus.out_data[MACW*8 +: MACW]), 12);
        @(negedge clk);
        check("toggle_done", 64'(bus.done), 1);
        @(negedge clk);

        // Back-pressure in HOLD with start pulses while busy.
        set_lanes(16'd1, 16'd1, 16'd1, 16'd1);
        bus.k_len = 8'd2;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        c = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            bus.start = 1'b0;
            if (bus.out_valid) break;
        end
        check("stall_latency", 64'(c), 6);
        held = bus.out_data[31:0];
        check("stall_value", 64'(held), 2);
        for (int s = 0; s < 5; s++) begin
            bus.start = (s == 1 || s == 2);
            bus.k_len = 8'd5;
            @(negedge clk);
            check($sformatf("stall_valid_%0d", s), 64'(bus.out_valid), 1);
            check($sformatf("stall_data_%0d", s), 64'(bus.out_data[MACW*8 +: MACW]), 2);
            check($sformatf("stall_nodone_%0d", s), 64'(bus.done), 0);
            check($sformatf("stall_busy_%0d", s), 64'(bus.busy), 1);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("stall_done", 64'(bus.done), 1);
        check("stall_valid_drop", 64'(bus.out_valid), 0);
        check("stall_data_kept", 64'(bus.out_data[31:0]), 2);
        @(negedge clk);
        check("stall_done_once", 64'(bus.done), 0);
        check("stall_start_ignored", 64'(bus.busy), 0);

        // Signed lanes: lane0 sums to -6, lane1 to +6.
        set_lanes(16'hFFFF, 16'd1, 16'd0, 16'd3);
        bus.k_len = 8'd2;
        bus.start = 1'b1;
        c = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            bus.start = 1'b0;
            if (bus.out_valid) break;
        end
        check("sign_latency", 64'(c), 6);
`ifdef MEISSA_COLUMN_CTRL_RELU_EN
        check("relu_lane0", 64'(bus.out_data[31:0]), 64'h0);
`else
        check("raw_lane0", 64'(bus.out_data[31:0]), 64'hFFFFFFFA);
`endif
        check("sign_lane1", 64'(bus.out_data[63:32]), 6);
        check("sign_lane2", 64'(bus.out_data[95:64]), 0);
        @(negedge clk);
        check("sign_done", 64'(bus.done), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
